// File: rtl/dmem_hs_if.sv
// Request/response handshake bundle between the MEM-stage load/store unit and dmem_hs.
interface dmem_hs_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [2:0]  rsp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_hs.sv
// RV32 word-organised data memory with one outstanding valid/ready transaction,
// configurable read latency, funct3 load/store formatting and fault reporting.
module dmem_hs #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned READ_LAT    = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic       clk,
    input  logic       rst,
    dmem_hs_if.slave   bus
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam int unsigned CW        = 3;
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic [2:0]      rsp_fault_q, rsp_fault_d;

    logic [31:0]     mem [DEPTH_WORDS] = '{default: 32'h0};

    logic            acc_c, idle_c, we_c, wr_en_c;
    logic [2:0]      f3_c, fault_c;
    logic [31:0]     addr_c, wdata_c, off_c, rd_word_c, ld_data_c, wd_c;
    logic [AW-1:0]   idx_c;
    logic [15:0]     lane_c;
    logic [3:0]      be_c;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_fault = rsp_fault_q;

    // In IDLE the live request is decoded so READ_LAT=1 can read at the accept edge.
    assign idle_c  = (state_q == IDLE);
    assign acc_c   = rst & bus.req_valid & req_ready_q;
    assign we_c    = idle_c ? bus.req_we     : we_q;
    assign f3_c    = idle_c ? bus.req_funct3 : f3_q;
    assign addr_c  = idle_c ? bus.req_addr   : addr_q;
    assign wdata_c = idle_c ? bus.req_wdata  : wdata_q;
    assign off_c   = addr_c - BASE_ADDR;
    assign idx_c   = off_c[AW+1:2];

    assign fault_c[2] = we_c ? !(f3_c inside {3'b000, 3'b001, 3'b010})
                             :  (f3_c inside {3'b011, 3'b110, 3'b111});
    assign fault_c[0] = ((f3_c == 3'b001 || f3_c == 3'b101) && addr_c[0]) ||
                        ((f3_c == 3'b010) && (addr_c[1:0] != 2'b00));
    assign fault_c[1] = (off_c >= MEM_BYTES);

    assign rd_word_c = mem[idx_c];
    assign lane_c    = 16'(rd_word_c >> {addr_c[1:0], 3'b000});
    assign wr_en_c   = acc_c & we_c & (fault_c == 3'b000);

    // Load formatting: sign/zero extension of the addressed lane.
    always_comb begin
        ld_data_c = 32'h0;
        case (f3_c)
            3'b000:  ld_data_c = {{24{lane_c[7]}}, lane_c[7:0]};
            3'b001:  ld_data_c = {{16{lane_c[15]}}, lane_c};
            3'b010:  ld_data_c = rd_word_c;
            3'b100:  ld_data_c = {24'h0, lane_c[7:0]};
            3'b101:  ld_data_c = {16'h0, lane_c};
            default: ld_data_c = 32'h0;
        endcase
    end

    // Store lane enables with data replicated across lanes.
    always_comb begin
        be_c = 4'hF;
        wd_c = wdata_c;
        case (f3_c[1:0])
            2'b00: begin
                be_c = 4'b0001 << addr_c[1:0];
                wd_c = {4{wdata_c[7:0]}};
            end
            2'b01: begin
                be_c = addr_c[1] ? 4'b1100 : 4'b0011;
                wd_c = {2{wdata_c[15:0]}};
            end
            default: begin
                be_c = 4'hF;
                wd_c = wdata_c;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) mem[idx_c][8*b +: 8] <= wd_c[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        case (state_q)
            IDLE: begin
                if (acc_c) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (READ_LAT == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(READ_LAT - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Response payload is captured on the edge that enters RESP and cleared on handshake.
        if (state_q != RESP && state_d == RESP) begin
            rsp_fault_d = fault_c;
            rsp_rdata_d = (!we_c && fault_c == 3'b000) ? ld_data_c : 32'h0;
        end else if (state_q == RESP && state_d == IDLE) begin
            rsp_fault_d = 3'b000;
            rsp_rdata_d = 32'h0;
        end
        rsp_valid_d = (state_d == RESP);
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_fault_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end
endmodule
